branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

In-flight branch bookkeeping between fetch-stage prediction and EX-stage resolution. Records every predicted branch in a small ordered queue at fetch and compares the actual outcome at EX against the oldest record. Emits the registered training bus consumed by the tournament/Gshare predictor (`Branch_EX`, `branchTaken`, `branch_target_EX`, index/history echoes). Generates the flush/redirect used by the PC mux on a misprediction.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `IW`, 5: width of GHPT index, GHR and BTB index fields.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high.
- `push_valid`, in, 1: fetch predicted a branch this cycle.
- `push_pc`, in, 32: branch PC.
- `push_pred_taken`, in, 1: predictor's `prediction`.
- `push_pred_addr`, in, 32: predictor's `predicted_address`.
- `push_ghpt_index`, in, IW: snapshot of `GHPT_index`.
- `push_ghr`, in, IW: snapshot of `GHR`.
- `push_btb_index`, in, IW: snapshot of `G_BTB_index`.
- `full`, out, 1: no free entry; fetch must stall branches.
- `empty`, out, 1: no entries.
- `res_valid`, in, 1: EX resolves the oldest branch.
- `res_taken`, in, 1: actual direction.
- `res_target`, in, 32: actual taken target.
- `Branch_EX`, out, 1: training bus valid.
- `branchTaken`, out, 1: resolved direction.
- `branch_target_EX`, out, 32: resolved target.
- `GHPT_index_in` / `GHR_in` / `G_BTB_index_in`, out, IW each: echoed snapshots.
- `flush`, out, 1: mispredict pulse.
- `redirect_pc`, out, 32: correct next PC, valid with `flush`.

## Operation
- Circular buffer, `DEPTH` entries. Read/write pointers carry an extra wrap bit. `full` is `ptr_w - ptr_r == DEPTH`; `empty` is pointer equality. Both are derived from registered pointers only.
- Push accepted iff `push_valid && !full && state==NORMAL`. A push while `full` is dropped, even if a resolve happens the same cycle.
- Resolve accepted iff `res_valid && !empty`. `res_valid` while empty is ignored: no training, no flush.
- Actual next PC = `res_taken ? res_target : pc+4`. Addition is 32-bit modulo.
- Mispredict = `res_taken != pred_taken`, or (`res_taken` and `res_target != pred_addr`).
- Every accepted resolve pops the oldest entry and drives the training bus on the next cycle.
- On mispredict:
  - All entries are discarded; pointers are set equal (younger entries are wrong-path).
  - A same-cycle push is dropped.
  - The FSM enters RECOVER.
- FSM:
  - NORMAL → RECOVER on a mispredicting resolve.
  - RECOVER → NORMAL unconditionally after 1 cycle.
  - In RECOVER, pushes and resolves are ignored, because wrong-path fetch/EX work is still draining.
- Simultaneous push and correct resolve: both take effect; occupancy is unchanged.

## Timing
- Reset values:
  - `Branch_EX`, `branchTaken`, `flush`: 0.
  - `branch_target_EX`, `redirect_pc`: 0.
  - Index/history outputs: 0.
  - `empty`=1, `full`=0, FSM=NORMAL.
- Resolve → training bus: 1 cycle, registered, `Branch_EX` high for exactly 1 cycle.
- Resolve → `flush`/`redirect_pc`: 1 cycle, same edge as the training bus, 1-cycle pulse.
- Push → entry visible to resolve: next cycle. Same-cycle push and resolve on an empty queue does not resolve the new entry.
- `Reset` mid-operation clears the queue and any pending pulse immediately (asynchronous).

## Configuration
- `BRQ_STATS_EN`:
  - Defined: adds outputs `resolved_count` [15:0] and `mispredict_count` [15:0]. They are saturating, increment on accepted resolves and on mispredicts respectively, and reset to 0.
  - Undefined: ports and counters are absent; functional behaviour is identical.

## Structure
- Shared package holds:
  - The entry struct: pc, pred_taken, pred_addr, ghpt_index, ghr, btb_index.
  - The FSM state enum: NORMAL, RECOVER.
  - Constant `INSTR_BYTES`=4.
- One sub-module: `brq_compare`. It is combinational; it takes the entry plus outcome and returns mispredict and the actual next PC.

## Test plan
- Reset → `empty`=1, `full`=0, all outputs 0; a `res_valid` pulse yields no `Branch_EX`.
- Push pc=0x100, pred taken to 0x200; resolve taken to 0x200 → next cycle `Branch_EX`=1, `branchTaken`=1, `branch_target_EX`=0x200, `flush`=0, `empty`=1.
- Push pc=0x100 pred not-taken, push pc=0x140; resolve taken to 0x300 → `flush`=1 and `redirect_pc`=0x300 for 1 cycle; queue empty; a push in the following cycle is ignored.
- Push pc=0x100 pred taken to 0x200; resolve not-taken → `flush`=1, `redirect_pc`=0x104.
- Four pushes → `full`=1; a fifth push with a simultaneous correct resolve → fifth push dropped, occupancy 3; snapshots echo in FIFO order.
- Assert `Reset` while 2 entries are queued and a flush is pending → `empty`=1 and `flush`=0 immediately; no training pulse follows.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
// Holds the queued entry layout, the recovery FSM state encodings
// and the instruction size used to form the fall-through PC.
package branch_resolve_queue_pkg;

    // Byte distance from a branch to its fall-through instruction.
    localparam int INSTR_BYTES = 4;

    // Width of the snapshot fields stored per entry. The top-level IW
    // parameter is cast to this width on push and back on the echo.
    localparam int BRQ_IW = 5;

    // Recovery FSM states.
    localparam logic [0:0] NORMAL  = 1'b0;
    localparam logic [0:0] RECOVER = 1'b1;

    // One in-flight predicted branch.
    typedef struct packed {
        logic [31:0]       pc;
        logic              pred_taken;
        logic [31:0]       pred_addr;
        logic [BRQ_IW-1:0] ghpt_index;
        logic [BRQ_IW-1:0] ghr;
        logic [BRQ_IW-1:0] btb_index;
    } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_compare.sv
// Combinational outcome check for the oldest queued branch.
// Produces the mispredict flag and the architecturally correct next PC.
module brq_compare (
    input  logic [31:0] entry_pc,
    input  logic        entry_pred_taken,
    input  logic [31:0] entry_pred_addr,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        mispredict,
    output logic [31:0] actual_next_pc
);
    import branch_resolve_queue_pkg::*;

    // A wrong direction, or a taken branch landing somewhere other than
    // the predicted target, both count as a mispredict.
    always_comb begin
        actual_next_pc = res_taken ? res_target : (entry_pc + 32'(INSTR_BYTES));
        mispredict     = (res_taken != entry_pred_taken) ||
                         (res_taken && (res_target != entry_pred_addr));
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-flight branch queue between fetch prediction and EX resolution.
// Drives the registered predictor training bus and the mispredict
// flush/redirect. Optional statistics counters are enabled by the
// BRQ_STATS_EN macro.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          push_valid,
    input  logic [31:0]   push_pc,
    input  logic          push_pred_taken,
    input  logic [31:0]   push_pred_addr,
    input  logic [IW-1:0] push_ghpt_index,
    input  logic [IW-1:0] push_ghr,
    input  logic [IW-1:0] push_btb_index,
    output logic          full,
    output logic          empty,
    input  logic          res_valid,
    input  logic          res_taken,
    input  logic [31:0]   res_target,
    output logic          Branch_EX,
    output logic          branchTaken,
    output logic [31:0]   branch_target_EX,
    output logic [IW-1:0] GHPT_index_in,
    output logic [IW-1:0] GHR_in,
    output logic [IW-1:0] G_BTB_index_in,
    output logic          flush,
    output logic [31:0]   redirect_pc
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]   resolved_count,
    output logic [15:0]   mispredict_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] ptr_w;
    logic [AW:0] ptr_r;
    logic [0:0]  state;
    brq_entry_t  mem [DEPTH];
    brq_entry_t  head;
    brq_entry_t  new_entry;
    logic        res_fire;
    logic        push_fire;
    logic        mispredict;
    logic        flush_now;
    logic [31:0] actual_next_pc;

    // Status and handshake decode from registered pointers and state only.
    always_comb begin
        empty     = (ptr_w == ptr_r);
        full      = (ptr_w[AW] != ptr_r[AW]) && (ptr_w[AW-1:0] == ptr_r[AW-1:0]);
        head      = mem[ptr_r[AW-1:0]];
        res_fire  = res_valid && !empty && (state == NORMAL);
        flush_now = res_fire && mispredict;
        push_fire = push_valid && !full && (state == NORMAL) && !flush_now;
    end

    // Pack the fetch-time snapshot into a queue entry.
    always_comb begin
        new_entry            = '0;
        new_entry.pc         = push_pc;
        new_entry.pred_taken = push_pred_taken;
        new_entry.pred_addr  = push_pred_addr;
        new_entry.ghpt_index = BRQ_IW'(push_ghpt_index);
        new_entry.ghr        = BRQ_IW'(push_ghr);
        new_entry.btb_index  = BRQ_IW'(push_btb_index);
    end

    brq_compare u_compare (
        .entry_pc         (head.pc),
        .entry_pred_taken (head.pred_taken),
        .entry_pred_addr  (head.pred_addr),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .mispredict       (mispredict),
        .actual_next_pc   (actual_next_pc)
    );

    // Entry storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[ptr_w[AW-1:0]] <= new_entry;
        end
    end

    // Pointer update; a mispredict collapses the queue onto the popped read pointer.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ptr_w <= '0;
            ptr_r <= '0;
        end else begin
            if (res_fire) begin
                ptr_r <= ptr_r + PTR_ONE;
            end
            if (flush_now) begin
                ptr_w <= ptr_r + PTR_ONE;
            end else if (push_fire) begin
                ptr_w <= ptr_w + PTR_ONE;
            end
        end
    end

    // Recovery FSM: one cycle of RECOVER after every mispredict.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= NORMAL;
        end else begin
            state <= flush_now ? RECOVER : NORMAL;
        end
    end

    // Registered training bus and flush/redirect, launched by an accepted resolve.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            Branch_EX        <= 1'b0;
            branchTaken      <= 1'b0;
            branch_target_EX <= '0;
            GHPT_index_in    <= '0;
            GHR_in           <= '0;
            G_BTB_index_in   <= '0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
        end else begin
            Branch_EX <= res_fire;
            flush     <= flush_now;
            if (res_fire) begin
                branchTaken      <= res_taken;
                branch_target_EX <= res_target;
                GHPT_index_in    <= IW'(head.ghpt_index);
                GHR_in           <= IW'(head.ghr);
                G_BTB_index_in   <= IW'(head.btb_index);
                redirect_pc      <= actual_next_pc;
            end
        end
    end

`ifdef BRQ_STATS_EN
    // Saturating counters of accepted resolves and mispredicts.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            resolved_count   <= '0;
            mispredict_count <= '0;
        end else begin
            if (res_fire && (resolved_count != 16'hFFFF)) begin
                resolved_count <= resolved_count + 16'd1;
            end
            if (flush_now && (mispredict_count != 16'hFFFF)) begin
                mispredict_count <= mispredict_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed testbench for branch_resolve_queue: a per-cycle vector table
// plus a hand-written asynchronous reset sequence.
module tb_branch_resolve_queue;

    logic        clk;
    logic        Reset;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_addr;
    logic [4:0]  push_ghpt_index;
    logic [4:0]  push_ghr;
    logic [4:0]  push_btb_index;
    logic        full;
    logic        empty;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        Branch_EX;
    logic        branchTaken;
    logic [31:0] branch_target_EX;
    logic [4:0]  GHPT_index_in;
    logic [4:0]  GHR_in;
    logic [4:0]  G_BTB_index_in;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BRQ_STATS_EN
    logic [15:0] resolved_count;
    logic [15:0] mispredict_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        pv;
        logic [31:0] ppc;
        logic        pt;
        logic [31:0] pa;
        logic [4:0]  gi;
        logic [4:0]  gh;
        logic [4:0]  bi;
        logic        rv;
        logic        rt;
        logic [31:0] rtgt;
        logic        e_bex;
        logic        e_taken;
        logic [31:0] e_tgt;
        logic        e_flush;
        logic [31:0] e_redir;
        logic        e_empty;
        logic        e_full;
        logic [4:0]  e_gi;
        logic [4:0]  e_gh;
        logic [4:0]  e_bi;
    } vec_t;

    vec_t vecs[$];

    branch_resolve_queue #(.DEPTH(4), .IW(5)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_addr   (push_pred_addr),
        .push_ghpt_index  (push_ghpt_index),
        .push_ghr         (push_ghr),
        .push_btb_index   (push_btb_index),
        .full             (full),
        .empty            (empty),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .Branch_EX        (Branch_EX),
        .branchTaken      (branchTaken),
        .branch_target_EX (branch_target_EX),
        .GHPT_index_in    (GHPT_index_in),
        .GHR_in           (GHR_in),
        .G_BTB_index_in   (G_BTB_index_in),
        .flush            (flush),
        .redirect_pc      (redirect_pc)
`ifdef BRQ_STATS_EN
        ,
        .resolved_count   (resolved_count),
        .mispredict_count (mispredict_count)
`endif
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string name,
        input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] pa,
        input logic [4:0] gi, input logic [4:0] gh, input logic [4:0] bi,
        input logic rv, input logic rt, input logic [31:0] rtgt,
        input logic e_bex, input logic e_taken, input logic [31:0] e_tgt,
        input logic e_flush, input logic [31:0] e_redir,
        input logic e_empty, input logic e_full,
        input logic [4:0] e_gi, input logic [4:0] e_gh, input logic [4:0] e_bi);
        vec_t v;
        v.name = name; v.pv = pv; v.ppc = ppc; v.pt = pt; v.pa = pa;
        v.gi = gi; v.gh = gh; v.bi = bi;
        v.rv = rv; v.rt = rt; v.rtgt = rtgt;
        v.e_bex = e_bex; v.e_taken = e_taken; v.e_tgt = e_tgt;
        v.e_flush = e_flush; v.e_redir = e_redir;
        v.e_empty = e_empty; v.e_full = e_full;
        v.e_gi = e_gi; v.e_gh = e_gh; v.e_bi = e_bi;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        push_valid      = 1'b0;
        push_pc         = '0;
        push_pred_taken = 1'b0;
        push_pred_addr  = '0;
        push_ghpt_index = '0;
        push_ghr        = '0;
        push_btb_index  = '0;
        res_valid       = 1'b0;
        res_taken       = 1'b0;
        res_target      = '0;
    endtask

    // Drive one cycle of inputs, clock it, and sample 1 unit after the edge.
    task automatic applyStimulus(input vec_t v);
        push_valid      = v.pv;
        push_pc         = v.ppc;
        push_pred_taken = v.pt;
        push_pred_addr  = v.pa;
        push_ghpt_index = v.gi;
        push_ghr        = v.gh;
        push_btb_index  = v.bi;
        res_valid       = v.rv;
        res_taken       = v.rt;
        res_target      = v.rtgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".Branch_EX"}, 32'(Branch_EX), 32'(v.e_bex));
        checkOutput({v.name, ".flush"},     32'(flush),     32'(v.e_flush));
        checkOutput({v.name, ".empty"},     32'(empty),     32'(v.e_empty));
        checkOutput({v.name, ".full"},      32'(full),      32'(v.e_full));
        if (v.e_bex) begin
            checkOutput({v.name, ".branchTaken"},      32'(branchTaken),    32'(v.e_taken));
            checkOutput({v.name, ".branch_target_EX"}, branch_target_EX,    v.e_tgt);
            checkOutput({v.name, ".GHPT_index_in"},    32'(GHPT_index_in),  32'(v.e_gi));
            checkOutput({v.name, ".GHR_in"},           32'(GHR_in),         32'(v.e_gh));
            checkOutput({v.name, ".G_BTB_index_in"},   32'(G_BTB_index_in), 32'(v.e_bi));
        end
        if (v.e_flush) begin
            checkOutput({v.name, ".redirect_pc"}, redirect_pc, v.e_redir);
        end
    endtask

    initial begin
        //              name               pv ppc           pt pa          gi gh bi  rv rt rtgt         bex tk tgt          fl redir       emp ful gi gh bi
        vecs.push_back(mk("res_on_empty",  0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 1, 32'h200,     0, 0, 32'h0,       0, 32'h0,      1, 0, 0, 0, 0));
        vecs.push_back(mk("push_a",        1, 32'h100,      1, 32'h200,    1, 2, 3,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("resolve_ok",    0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 1, 32'h200,     1, 1, 32'h200,     0, 32'h0,      1, 0, 1, 2, 3));
        vecs.push_back(mk("idle_a",        0, 32'h0,        0, 32'h0,      0, 0, 0,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      1, 0, 0, 0, 0));
        vecs.push_back(mk("push_nt",       1, 32'h100,      0, 32'h0,      4, 5, 6,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("push_young",    1, 32'h140,      1, 32'h180,    7, 8, 9,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("mp_dir",        0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 1, 32'h300,     1, 1, 32'h300,     1, 32'h300,    1, 0, 4, 5, 6));
        vecs.push_back(mk("push_recover",  1, 32'h500,      0, 32'h0,      1, 1, 1,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      1, 0, 0, 0, 0));
        vecs.push_back(mk("res_post_rec",  0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      1, 0, 0, 0, 0));
        vecs.push_back(mk("push_b",        1, 32'h100,      1, 32'h200,   10,11,12,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("mp_not_taken",  0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 0, 32'h0,       1, 0, 32'h0,       1, 32'h104,    1, 0,10,11,12));
        vecs.push_back(mk("idle_b",        0, 32'h0,        0, 32'h0,      0, 0, 0,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      1, 0, 0, 0, 0));
        vecs.push_back(mk("fill_1",        1, 32'h1000,     0, 32'h0,      1, 1, 1,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("fill_2",        1, 32'h2000,     1, 32'h2400,   2, 2, 2,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("fill_3",        1, 32'h3000,     0, 32'h0,      3, 3, 3,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("fill_4",        1, 32'h4000,     1, 32'h4800,   4, 5, 6,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 1, 0, 0, 0));
        vecs.push_back(mk("push_full_res", 1, 32'h5000,     0, 32'h0,      9, 9, 9,  1, 0, 32'h0,       1, 0, 32'h0,       0, 32'h0,      0, 0, 1, 1, 1));
        vecs.push_back(mk("drain_2",       0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 1, 32'h2400,    1, 1, 32'h2400,    0, 32'h0,      0, 0, 2, 2, 2));
        vecs.push_back(mk("drain_3",       0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 0, 32'h0,       1, 0, 32'h0,       0, 32'h0,      0, 0, 3, 3, 3));
        vecs.push_back(mk("drain_4",       0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 1, 32'h4800,    1, 1, 32'h4800,    0, 32'h0,      1, 0, 4, 5, 6));
        vecs.push_back(mk("res_empty_2",   0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      1, 0, 0, 0, 0));
        vecs.push_back(mk("push_res_same", 1, 32'h700,      1, 32'h740,    7, 7, 7,  1, 1, 32'h740,     0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("res_same_next", 0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 1, 32'h740,     1, 1, 32'h740,     0, 32'h0,      1, 0, 7, 7, 7));
        vecs.push_back(mk("push_tgt",      1, 32'h800,      1, 32'h900,    1, 2, 3,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("mp_target",     0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 1, 32'h904,     1, 1, 32'h904,     1, 32'h904,    1, 0, 1, 2, 3));
        vecs.push_back(mk("idle_c",        0, 32'h0,        0, 32'h0,      0, 0, 0,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      1, 0, 0, 0, 0));
        vecs.push_back(mk("push_wrap",     1, 32'hFFFFFFFC, 1, 32'h10,     3, 2, 1,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("mp_pc_wrap",    0, 32'h0,        0, 32'h0,      0, 0, 0,  1, 0, 32'h0,       1, 0, 32'h0,       1, 32'h0,      1, 0, 3, 2, 1));
        vecs.push_back(mk("idle_d",        0, 32'h0,        0, 32'h0,      0, 0, 0,  0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,      1, 0, 0, 0, 0));

        driveIdle();
        Reset = 1'b1;
        #22;
        Reset = 1'b0;
        #1;

        checkOutput("reset.empty",            32'(empty),            32'd1);
        checkOutput("reset.full",             32'(full),             32'd0);
        checkOutput("reset.Branch_EX",        32'(Branch_EX),        32'd0);
        checkOutput("reset.branchTaken",      32'(branchTaken),      32'd0);
        checkOutput("reset.branch_target_EX", branch_target_EX,      32'd0);
        checkOutput("reset.flush",            32'(flush),            32'd0);
        checkOutput("reset.redirect_pc",      redirect_pc,           32'd0);
        checkOutput("reset.GHPT_index_in",    32'(GHPT_index_in),    32'd0);
        checkOutput("reset.GHR_in",           32'(GHR_in),           32'd0);
        checkOutput("reset.G_BTB_index_in",   32'(G_BTB_index_in),   32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i]);
        end
        driveIdle();

`ifdef BRQ_STATS_EN
        checkOutput("stats.resolved_count",   32'(resolved_count),   32'd10);
        checkOutput("stats.mispredict_count", 32'(mispredict_count), 32'd4);
`endif

        // Two entries queued, then a mispredicting resolve is presented and
        // Reset arrives before the edge that would launch the flush.
        push_valid = 1'b1; push_pc = 32'hA00; push_pred_taken = 1'b0; push_pred_addr = 32'h0;
        @(posedge clk); #1;
        push_pc = 32'hA40;
        @(posedge clk); #1;
        driveIdle();
        checkOutput("rst_seq.empty_before", 32'(empty), 32'd0);
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        res_target = 32'hB00;
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("rst_seq.empty_now",     32'(empty),     32'd1);
        checkOutput("rst_seq.flush_now",     32'(flush),     32'd0);
        checkOutput("rst_seq.Branch_EX_now", 32'(Branch_EX), 32'd0);
        @(posedge clk); #1;
        checkOutput("rst_seq.flush_held",     32'(flush),     32'd0);
        checkOutput("rst_seq.Branch_EX_held", 32'(Branch_EX), 32'd0);
        driveIdle();
        #2;
        Reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_seq.flush_after",     32'(flush),     32'd0);
        checkOutput("rst_seq.Branch_EX_after", 32'(Branch_EX), 32'd0);
        checkOutput("rst_seq.empty_after",     32'(empty),     32'd1);
`ifdef BRQ_STATS_EN
        checkOutput("rst_seq.resolved_count", 32'(resolved_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
